lcd_cmd_seq: RTL and testbench

Command sequencer in front of the LCD image controller core. Buffers image-operation commands from a host in a small FIFO and issues them one at a time on the core's `cmd`/`cmd_valid` port, respecting the core's `busy` flag. After the write-back command it tracks completion through the core's `done` flag. Sits between the host/testbench command source and the LCD controller; the IROM/IRB memory ports stay wired directly to the core.

---
 rtl/lcd_cmd_seq.sv | 111 +++++++++++
 tb/tb_lcd_cmd_seq.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_seq.sv
// lcd_cmd_seq: buffers host image commands in a FIFO and issues them one at a time to the LCD core, tracking write-back completion; define LCD_SEQ_WDOG_EN to add the INIT/WAITWB watchdog and wdog_err port
module lcd_cmd_seq #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  host_cmd,
  input  logic        host_valid,
  output logic        host_ready,
  output logic [2:0]  cmd,
  output logic        cmd_valid,
  input  logic        busy,
  input  logic        done,
  output logic [AW:0] fifo_count,
  output logic        seq_done
`ifdef LCD_SEQ_WDOG_EN
  ,
  output logic        wdog_err
`endif
);

  typedef enum logic [2:0] {INIT, READY, ISSUE, GAP, WAITWB, FIN} state_t;

  state_t        state, state_n;
  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count_n;
  logic [2:0]    cmd_n;
  logic          cmd_valid_n, seq_done_n, wb_seen, wb_seen_n, ready_n;
  logic          push, pop, wdog_hit;

`ifdef LCD_SEQ_WDOG_EN
  logic [7:0] wcnt, wcnt_n;
  logic       wdog_err_n;
  assign wdog_hit = wcnt == 8'hff;
`else
  assign wdog_hit = 1'b0;
`endif

  assign push = host_valid && host_ready;

  // next-state and registered-output values; entering FIN always marks the sequence complete
  always_comb begin
    state_n     = state;
    pop         = 1'b0;
    cmd_n       = cmd;
    cmd_valid_n = 1'b0;
    case (state)
      INIT:    state_n = !busy ? READY : (wdog_hit ? FIN : INIT);
      READY:
        if (fifo_count != '0 && !busy) begin
          pop         = 1'b1;
          cmd_n       = mem[rptr];
          cmd_valid_n = 1'b1;
          state_n     = ISSUE;
        end
      ISSUE:   state_n = (cmd == 3'd0) ? WAITWB : GAP;
      GAP:     state_n = READY;
      WAITWB:  state_n = (done || wdog_hit) ? FIN : WAITWB;
      default: state_n = FIN;
    endcase
    seq_done_n = seq_done || state_n == FIN;
    count_n    = fifo_count + (AW+1)'(push) - (AW+1)'(pop);
    wb_seen_n  = wb_seen || (push && host_cmd == 3'd0);
    ready_n    = count_n != (AW+1)'(DEPTH) && !wb_seen_n && state_n != FIN;
`ifdef LCD_SEQ_WDOG_EN
    wcnt_n     = (state_n == state) ? wcnt + 8'd1 : 8'd0;
    wdog_err_n = wdog_err || (wdog_hit && ((state == INIT && busy) || (state == WAITWB && !done)));
`endif
  end

  // state, pointers and all outputs; async reset drops any buffered commands
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= INIT;
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
      wb_seen    <= 1'b0;
      host_ready <= 1'b0;
      cmd        <= 3'd0;
      cmd_valid  <= 1'b0;
      seq_done   <= 1'b0;
`ifdef LCD_SEQ_WDOG_EN
      wcnt       <= 8'd0;
      wdog_err   <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      wptr       <= push ? wptr + AW'(1) : wptr;
      rptr       <= pop ? rptr + AW'(1) : rptr;
      fifo_count <= count_n;
      wb_seen    <= wb_seen_n;
      host_ready <= ready_n;
      cmd        <= cmd_n;
      cmd_valid  <= cmd_valid_n;
      seq_done   <= seq_done_n;
`ifdef LCD_SEQ_WDOG_EN
      wcnt       <= wcnt_n;
      wdog_err   <= wdog_err_n;
`endif
    end
  end

  // FIFO storage needs no reset; the cleared pointers make old contents unreachable
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= host_cmd;
  end

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// tb_lcd_cmd_seq: randomized scenario bench for lcd_cmd_seq against a queue-based command model
module tb_lcd_cmd_seq;

  logic       clk = 1'b0, reset = 1'b1, host_valid = 1'b0, busy = 1'b1, done = 1'b0;
  logic [2:0] host_cmd = 3'd0;
  logic       host_ready, cmd_valid, seq_done;
  logic [2:0] cmd;
  logic [3:0] fifo_count;
`ifdef LCD_SEQ_WDOG_EN
  logic       wdog_err;
`endif

  int passed = 0, total = 0, cyc = 0;
  logic [2:0] pushed[$];
  logic [2:0] issued[$];
  int         icyc[$];

  lcd_cmd_seq #(.DEPTH(8), .AW(3)) dut (
    .clk(clk), .reset(reset), .host_cmd(host_cmd), .host_valid(host_valid),
    .host_ready(host_ready), .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy),
    .done(done), .fifo_count(fifo_count), .seq_done(seq_done)
`ifdef LCD_SEQ_WDOG_EN
    , .wdog_err(wdog_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    logic p;
    p = host_valid && host_ready;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (p) pushed.push_back(host_cmd);
    if (cmd_valid) begin
      issued.push_back(cmd);
      icyc.push_back(cyc);
    end
  endtask

  task automatic clear_log();
    pushed.delete();
    issued.delete();
    icyc.delete();
  endtask

  task automatic do_reset(input logic b);
    reset = 1'b1; host_valid = 1'b0; done = 1'b0; busy = b;
    tick(); tick();
    reset = 1'b0;
    clear_log();
    cyc = 0;
  endtask

  task automatic drain(input int budget, output bit to);
    host_valid = 1'b0; busy = 1'b0;
    for (int i = 0; i < budget && issued.size() < pushed.size(); i++) tick();
    to = issued.size() < pushed.size();
    tick(); tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; busy = 1'b1; host_valid = 1'b1; host_cmd = 3'd3;
    tick(); tick();
    total++; if (cmd !== 3'd0) $display("FAIL reset_cmd got=%0d exp=0", cmd); else passed++;
    total++; if (cmd_valid !== 1'b0) $display("FAIL reset_cmd_valid got=%b exp=0", cmd_valid); else passed++;
    total++; if (host_ready !== 1'b0) $display("FAIL reset_host_ready got=%b exp=0", host_ready); else passed++;
    total++; if (fifo_count !== 4'd0) $display("FAIL reset_fifo_count got=%0d exp=0", fifo_count); else passed++;
    total++; if (seq_done !== 1'b0) $display("FAIL reset_seq_done got=%b exp=0", seq_done); else passed++;
`ifdef LCD_SEQ_WDOG_EN
    total++; if (wdog_err !== 1'b0) $display("FAIL reset_wdog_err got=%b exp=0", wdog_err); else passed++;
`endif
    host_valid = 1'b0; reset = 1'b0;
    clear_log(); cyc = 0;
    tick();
    total++; if (host_ready !== 1'b1) $display("FAIL post_reset_host_ready got=%b exp=1", host_ready); else passed++;
  endtask

  task automatic test_init_wait();
    do_reset(1'b1);
    for (int i = 0; i < 150 && issued.size() < 2; i++) begin
      busy = cyc < 65;
      host_valid = cyc >= 2 && pushed.size() < 2;
      host_cmd = (pushed.size() == 0) ? 3'd4 : 3'd1;
      tick();
    end
    host_valid = 1'b0;
    total++; if (issued.size() != 2) $display("FAIL init_issue_count got=%0d exp=2", issued.size()); else passed++;
    if (issued.size() == 2) begin
      total++; if (issued[0] !== 3'd4) $display("FAIL init_first_cmd got=%0d exp=4", issued[0]); else passed++;
      total++; if (issued[1] !== 3'd1) $display("FAIL init_second_cmd got=%0d exp=1", issued[1]); else passed++;
      total++; if (icyc[0] != 67) $display("FAIL init_first_issue_cycle got=%0d exp=67", icyc[0]); else passed++;
      total++; if (icyc[1] - icyc[0] != 3) $display("FAIL init_issue_spacing got=%0d exp=3", icyc[1] - icyc[0]); else passed++;
    end
    tick(); tick(); tick();
    total++; if (issued.size() != 2) $display("FAIL init_single_strobe got=%0d exp=2", issued.size()); else passed++;
    total++; if (cmd_valid !== 1'b0) $display("FAIL init_idle_valid got=%b exp=0", cmd_valid); else passed++;
  endtask

  task automatic test_latency();
    logic [2:0] c;
    clear_log();
    busy = 1'b0;
    c = 3'($urandom_range(1, 7));
    host_valid = 1'b1; host_cmd = c;
    tick();
    host_valid = 1'b0;
    total++; if (cmd_valid !== 1'b0) $display("FAIL lat_n_valid got=%b exp=0", cmd_valid); else passed++;
    total++; if (fifo_count !== 4'd1) $display("FAIL lat_n_count got=%0d exp=1", fifo_count); else passed++;
    tick();
    total++; if (cmd_valid !== 1'b1) $display("FAIL lat_n1_valid got=%b exp=1", cmd_valid); else passed++;
    total++; if (cmd !== c) $display("FAIL lat_n1_cmd got=%0d exp=%0d", cmd, c); else passed++;
    total++; if (fifo_count !== 4'd0) $display("FAIL lat_n1_count got=%0d exp=0", fifo_count); else passed++;
    tick();
    total++; if (cmd_valid !== 1'b0) $display("FAIL lat_issue_valid got=%b exp=0", cmd_valid); else passed++;
    total++; if (cmd !== c) $display("FAIL lat_issue_hold got=%0d exp=%0d", cmd, c); else passed++;
    tick();
    total++; if (cmd !== c) $display("FAIL lat_gap_hold got=%0d exp=%0d", cmd, c); else passed++;
    tick();
  endtask

  task automatic test_fill_wrap();
    bit to;
    clear_log();
    busy = 1'b1; host_valid = 1'b1;
    for (int i = 0; i < 20 && pushed.size() < 8; i++) begin
      host_cmd = 3'($urandom_range(1, 7));
      tick();
    end
    total++; if (fifo_count !== 4'd8) $display("FAIL fill_count got=%0d exp=8", fifo_count); else passed++;
    total++; if (host_ready !== 1'b0) $display("FAIL fill_host_ready got=%b exp=0", host_ready); else passed++;
    tick();
    total++; if (fifo_count !== 4'd8) $display("FAIL fill_no_overflow got=%0d exp=8", fifo_count); else passed++;
    host_valid = 1'b0; busy = 1'b0;
    for (int i = 0; i < 60 && issued.size() < 8; i++) begin
      tick();
      total++;
      if (fifo_count !== 4'(pushed.size() - issued.size()))
        $display("FAIL fill_drain_count got=%0d exp=%0d", fifo_count, pushed.size() - issued.size());
      else passed++;
    end
    drain(10, to);
    total++; if (issued.size() != 8) $display("FAIL fill_issue_count got=%0d exp=8", issued.size()); else passed++;
    for (int i = 0; i < issued.size() && i < pushed.size(); i++) begin
      total++; if (issued[i] !== pushed[i]) $display("FAIL fill_order[%0d] got=%0d exp=%0d", i, issued[i], pushed[i]); else passed++;
    end
  endtask

  task automatic test_push_pop();
    logic [2:0] x;
    bit to;
    clear_log();
    busy = 1'b1; host_valid = 1'b1;
    for (int i = 0; i < 10 && pushed.size() < 3; i++) begin
      host_cmd = 3'($urandom_range(1, 7));
      tick();
    end
    x = 3'($urandom_range(1, 7));
    busy = 1'b0; host_cmd = x;
    tick();
    host_valid = 1'b0;
    total++; if (fifo_count !== 4'd3) $display("FAIL pp_count got=%0d exp=3", fifo_count); else passed++;
    total++; if (cmd_valid !== 1'b1) $display("FAIL pp_issue got=%b exp=1", cmd_valid); else passed++;
    drain(40, to);
    total++; if (to || issued.size() != 4) $display("FAIL pp_issue_count got=%0d exp=4", issued.size()); else passed++;
    if (issued.size() == 4) begin
      total++; if (issued[3] !== x) $display("FAIL pp_last got=%0d exp=%0d", issued[3], x); else passed++;
    end
    for (int i = 0; i < issued.size() && i < pushed.size(); i++) begin
      total++; if (issued[i] !== pushed[i]) $display("FAIL pp_order[%0d] got=%0d exp=%0d", i, issued[i], pushed[i]); else passed++;
    end
  endtask

  task automatic test_random();
    bit to;
    int min_gap;
    clear_log();
    for (int i = 0; i < 120; i++) begin
      host_valid = 1'($urandom_range(0, 1));
      host_cmd = 3'($urandom_range(1, 7));
      busy = $urandom_range(0, 3) == 0;
      done = $urandom_range(0, 7) == 0;
      tick();
      total++;
      if (fifo_count !== 4'(pushed.size() - issued.size()))
        $display("FAIL rnd_count got=%0d exp=%0d", fifo_count, pushed.size() - issued.size());
      else passed++;
      total++;
      if (host_ready !== (pushed.size() - issued.size() < 8))
        $display("FAIL rnd_host_ready got=%b exp=%b", host_ready, pushed.size() - issued.size() < 8);
      else passed++;
      total++; if (seq_done !== 1'b0) $display("FAIL rnd_seq_done got=%b exp=0", seq_done); else passed++;
    end
    done = 1'b0;
    drain(60, to);
    total++; if (to) $display("FAIL rnd_drain got=%0d exp=%0d", issued.size(), pushed.size()); else passed++;
    for (int i = 0; i < issued.size() && i < pushed.size(); i++) begin
      total++; if (issued[i] !== pushed[i]) $display("FAIL rnd_order[%0d] got=%0d exp=%0d", i, issued[i], pushed[i]); else passed++;
    end
    min_gap = 3;
    for (int i = 1; i < icyc.size(); i++) if (icyc[i] - icyc[i-1] < min_gap) min_gap = icyc[i] - icyc[i-1];
    total++; if (min_gap < 3) $display("FAIL rnd_min_spacing got=%0d exp>=3", min_gap); else passed++;
  endtask

  task automatic test_writeback();
    logic [2:0] seq [4];
    clear_log();
    seq[0] = 3'd5; seq[1] = 3'd6; seq[2] = 3'd7; seq[3] = 3'd0;
    busy = 1'b0; host_valid = 1'b1;
    for (int i = 0; i < 20 && pushed.size() < 4; i++) begin
      host_cmd = seq[pushed.size()];
      tick();
    end
    host_valid = 1'b0;
    total++; if (host_ready !== 1'b0) $display("FAIL wb_host_ready got=%b exp=0", host_ready); else passed++;
    for (int i = 0; i < 40 && issued.size() < 4; i++) tick();
    total++; if (issued.size() != 4) $display("FAIL wb_issue_count got=%0d exp=4", issued.size()); else passed++;
    for (int i = 0; i < issued.size(); i++) begin
      total++; if (issued[i] !== seq[i]) $display("FAIL wb_order[%0d] got=%0d exp=%0d", i, issued[i], seq[i]); else passed++;
    end
    for (int i = 0; i < 69; i++) tick();
    total++; if (seq_done !== 1'b0) $display("FAIL wb_early_done got=%b exp=0", seq_done); else passed++;
    done = 1'b1;
    tick();
    done = 1'b0;
    total++; if (seq_done !== 1'b1) $display("FAIL wb_seq_done got=%b exp=1", seq_done); else passed++;
    host_valid = 1'b1; host_cmd = 3'd3;
    for (int i = 0; i < 4; i++) tick();
    host_valid = 1'b0;
    total++; if (host_ready !== 1'b0) $display("FAIL fin_host_ready got=%b exp=0", host_ready); else passed++;
    total++; if (fifo_count !== 4'd0) $display("FAIL fin_count got=%0d exp=0", fifo_count); else passed++;
    total++; if (issued.size() != 4) $display("FAIL fin_no_issue got=%0d exp=4", issued.size()); else passed++;
    total++; if (seq_done !== 1'b1) $display("FAIL fin_sticky got=%b exp=1", seq_done); else passed++;
  endtask

  task automatic test_reset_async_fifo();
    do_reset(1'b1);
    host_valid = 1'b1;
    for (int i = 0; i < 10 && pushed.size() < 3; i++) begin
      host_cmd = 3'($urandom_range(1, 7));
      tick();
    end
    host_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    total++; if (fifo_count !== 4'd0) $display("FAIL async_fifo_count got=%0d exp=0", fifo_count); else passed++;
    total++; if (host_ready !== 1'b0) $display("FAIL async_host_ready got=%b exp=0", host_ready); else passed++;
    @(negedge clk);
    reset = 1'b0;
    clear_log(); cyc = 0;
  endtask

  task automatic test_reset_waitwb();
    do_reset(1'b0);
    tick();
    host_valid = 1'b1;
    for (int i = 0; i < 10 && pushed.size() < 2; i++) begin
      host_cmd = (pushed.size() == 0) ? 3'd3 : 3'd0;
      tick();
    end
    host_valid = 1'b0;
    for (int i = 0; i < 30 && issued.size() < 2; i++) tick();
    tick(); tick();
    total++; if (issued.size() != 2) $display("FAIL rwb_reach_waitwb got=%0d exp=2", issued.size()); else passed++;
    #2 reset = 1'b1;
    #1;
    total++; if (cmd_valid !== 1'b0) $display("FAIL rwb_cmd_valid got=%b exp=0", cmd_valid); else passed++;
    total++; if (seq_done !== 1'b0) $display("FAIL rwb_seq_done got=%b exp=0", seq_done); else passed++;
    total++; if (cmd !== 3'd0) $display("FAIL rwb_cmd got=%0d exp=0", cmd); else passed++;
    @(negedge clk);
    reset = 1'b0;
    clear_log(); cyc = 0;
    busy = 1'b1;
    tick();
    total++; if (host_ready !== 1'b1) $display("FAIL rwb_host_ready got=%b exp=1", host_ready); else passed++;
    host_valid = 1'b1; host_cmd = 3'd2;
    tick();
    host_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    total++; if (issued.size() != 0) $display("FAIL rwb_init_hold got=%0d exp=0", issued.size()); else passed++;
    total++; if (fifo_count !== 4'd1) $display("FAIL rwb_count got=%0d exp=1", fifo_count); else passed++;
    busy = 1'b0;
    for (int i = 0; i < 10 && issued.size() < 1; i++) tick();
    total++; if (issued.size() != 1 || issued[0] !== 3'd2) $display("FAIL rwb_after_init got=%0d exp=1 issue of 2", issued.size()); else passed++;
  endtask

  task automatic test_wdog();
    int fire = 0;
    do_reset(1'b1);
`ifdef LCD_SEQ_WDOG_EN
    for (int i = 0; i < 300 && fire == 0; i++) begin
      host_valid = pushed.size() == 0;
      host_cmd = 3'd5;
      tick();
      if (wdog_err === 1'b1) fire = cyc;
    end
    host_valid = 1'b0;
    total++; if (fire != 256) $display("FAIL wdog_fire_cycle got=%0d exp=256", fire); else passed++;
    total++; if (seq_done !== 1'b1) $display("FAIL wdog_seq_done got=%b exp=1", seq_done); else passed++;
    total++; if (host_ready !== 1'b0) $display("FAIL wdog_host_ready got=%b exp=0", host_ready); else passed++;
`else
    for (int i = 0; i < 300; i++) begin
      host_valid = pushed.size() == 0;
      host_cmd = 3'd5;
      tick();
    end
    host_valid = 1'b0;
    total++; if (seq_done !== 1'b0) $display("FAIL nowdog_seq_done got=%b exp=0", seq_done); else passed++;
    total++; if (fifo_count !== 4'd1) $display("FAIL nowdog_count got=%0d exp=1", fifo_count); else passed++;
`endif
    total++; if (issued.size() != 0) $display("FAIL wdog_no_issue got=%0d exp=0", issued.size()); else passed++;
  endtask

  initial begin
    test_reset();
    test_init_wait();
    test_latency();
    test_fill_wrap();
    test_push_pop();
    test_random();
    test_writeback();
    test_reset_async_fifo();
    test_reset_waitwb();
    test_wdog();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
